// File: rtl/ring_phase_monitor.sv
// ring_phase_monitor
//   Watches the one-hot phase vector of a ring counter. Each cycle it checks
//   that the vector is one-hot and that it rotated left by exactly one place
//   (bit i -> bit i+1, MSB -> bit 0). It locks after LOCK_CYC consecutive
//   legal steps, reports the phase as a binary index, pulses on each full
//   rotation, counts rotations and latches a sticky error with a cause code.
//
//   Pipeline: stage 1 registers phase_in into ph_q; stage 2 compares ph_q
//   with the previous sample ph_prev and updates the FSM and every output.
//   All outputs are registered, two edges after phase_in is sampled.
//
// Ports
//   clk       in   system clock, rising edge
//   rstn      in   asynchronous active-low reset
//   phase_in  in   [WIDTH]  one-hot phase from the ring counter
//   clr_err   in   clear sticky error (acts only in ERROR)
//   idx       out  [IDXW]   binary index of the last one-hot phase
//   locked    out  high while tracking
//   wrap      out  one-cycle pulse on a tracked WIDTH-1 -> 0 step
//   rot_cnt   out  [CNTW]   rotations seen while tracking (modulo 2^CNTW)
//   err       out  sticky error flag
//   err_code  out  [2]  00 none, 01 not one-hot, 10 illegal step
module ring_phase_monitor #(
   parameter int WIDTH    = 4,
   parameter int IDXW     = 2,
   parameter int LOCK_CYC = 4,
   parameter int CNTW     = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [WIDTH-1:0] phase_in,
   input  logic             clr_err,
   output logic [IDXW-1:0]  idx,
   output logic             locked,
   output logic             wrap,
   output logic [CNTW-1:0]  rot_cnt,
   output logic             err,
   output logic [1:0]       err_code
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACQ   = 2'd1,
      S_TRACK = 2'd2,
      S_ERROR = 2'd3
   } state_t;

   localparam logic [1:0] CODE_NONE   = 2'b00;
   localparam logic [1:0] CODE_NOT_OH = 2'b01;
   localparam logic [1:0] CODE_STEP   = 2'b10;

   state_t           state, state_n;
   logic [WIDTH-1:0] ph_q, ph_prev;
   logic [7:0]       acq_cnt, acq_n;
   logic [8:0]       acq_inc;
   logic [CNTW-1:0]  rot_n;
   logic             wrap_n, err_n;
   logic [1:0]       code_n;
   logic             oh, step_ok, wrap_step;
   logic [IDXW-1:0]  enc;

   // One-hot: nonzero and clearing the lowest set bit leaves nothing.
   assign oh        = (ph_q != '0) && ((ph_q & (ph_q - WIDTH'(1))) == '0);
   assign step_ok   = oh && (ph_q == {ph_prev[WIDTH-2:0], ph_prev[WIDTH-1]});
   assign wrap_step = ph_prev[WIDTH-1] && ph_q[0];
   assign acq_inc   = {1'b0, acq_cnt} + 9'd1;

   // OR-encoder; only meaningful when ph_q is one-hot.
   always_comb begin
      enc = '0;
      for (int i = 0; i < WIDTH; i++)
         if (ph_q[i]) enc = enc | IDXW'(i);
   end

   always_comb begin
      state_n = state;
      acq_n   = acq_cnt;
      rot_n   = rot_cnt;
      wrap_n  = 1'b0;
      err_n   = err;
      code_n  = err_code;
      unique case (state)
         S_IDLE: begin
            if (oh) begin
               state_n = S_ACQ;
               acq_n   = '0;
            end
         end
         S_ACQ: begin
            if (!oh) begin
               state_n = S_IDLE;
            end else if (step_ok) begin
               // The step that completes lock never reports a wrap.
               if (acq_inc == 9'(LOCK_CYC)) begin
                  state_n = S_TRACK;
                  acq_n   = '0;
               end else begin
                  acq_n = acq_inc[7:0];
               end
            end else begin
               acq_n = '0;
            end
         end
         S_TRACK: begin
            if (step_ok) begin
               if (wrap_step) begin
                  wrap_n = 1'b1;
                  rot_n  = rot_cnt + CNTW'(1);
               end
            end else begin
               state_n = S_ERROR;
               err_n   = 1'b1;
               code_n  = oh ? CODE_STEP : CODE_NOT_OH;
            end
         end
         S_ERROR: begin
            // clear takes priority over anything seen on this edge
            if (clr_err) begin
               state_n = S_IDLE;
               err_n   = 1'b0;
               code_n  = CODE_NONE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= S_IDLE;
         ph_q     <= '0;
         ph_prev  <= '0;
         acq_cnt  <= '0;
         idx      <= '0;
         locked   <= 1'b0;
         wrap     <= 1'b0;
         rot_cnt  <= '0;
         err      <= 1'b0;
         err_code <= CODE_NONE;
      end else begin
         state    <= state_n;
         ph_q     <= phase_in;
         ph_prev  <= ph_q;
         acq_cnt  <= acq_n;
         if (oh) idx <= enc;
         locked   <= (state_n == S_TRACK);
         wrap     <= wrap_n;
         rot_cnt  <= rot_n;
         err      <= err_n;
         err_code <= code_n;
      end
   end

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Scoreboard bench for ring_phase_monitor (WIDTH=4, LOCK_CYC=4, CNTW=8).
// The driver computes the expected outputs for each edge with a positional
// reference model and queues them; a monitor pops one entry after every
// clock edge (or asynchronous reset assertion) and compares.
module tb_ring_phase_monitor;

   localparam int W    = 4;
   localparam int LOCK = 4;

   logic       clk = 1'b0;
   logic       rstn;
   logic [3:0] phase_in;
   logic       clr_err;
   logic [1:0] idx;
   logic       locked, wrap, err;
   logic [7:0] rot_cnt;
   logic [1:0] err_code;

   ring_phase_monitor #(.WIDTH(4), .IDXW(2), .LOCK_CYC(LOCK), .CNTW(8)) dut (
      .clk(clk), .rstn(rstn), .phase_in(phase_in), .clr_err(clr_err),
      .idx(idx), .locked(locked), .wrap(wrap), .rot_cnt(rot_cnt),
      .err(err), .err_code(err_code)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] idx;
      logic       locked;
      logic       wrap;
      logic [7:0] rot;
      logic       err;
      logic [1:0] code;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   failures = 0;

   // ---------------- reference model ----------------
   // mode: 0 idle, 1 acquiring, 2 tracking, 3 error
   logic [3:0] m_phq, m_prev;
   int         m_mode, m_run, m_idx, m_rot, m_code;
   bit         m_err;

   function automatic int pos_of(input logic [3:0] v);
      if ($countones(v) != 1) return -1;
      for (int i = 0; i < W; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic logic [3:0] rl(input logic [3:0] v);
      return {v[2:0], v[3]};
   endfunction

   task automatic m_reset();
      m_phq = 0; m_prev = 0; m_mode = 0; m_run = 0;
      m_idx = 0; m_rot = 0; m_err = 0; m_code = 0;
   endtask

   function automatic exp_t m_snapshot(input bit w);
      exp_t e;
      e.idx = 2'(m_idx); e.locked = (m_mode == 2); e.wrap = w;
      e.rot = 8'(m_rot); e.err = m_err; e.code = 2'(m_code);
      return e;
   endfunction

   // Evaluate one edge: compare held sample with the one before it.
   task automatic m_edge(input logic [3:0] pin, input logic clr);
      int  p, pp;
      bit  legal, w;
      p  = pos_of(m_phq);
      pp = pos_of(m_prev);
      legal = (p >= 0) && (pp >= 0) && (p == (pp + 1) % W);
      w = 0;
      case (m_mode)
         0: if (p >= 0) begin m_mode = 1; m_run = 0; end
         1: begin
            if (p < 0) m_mode = 0;
            else if (legal) begin
               m_run++;
               if (m_run == LOCK) m_mode = 2;
            end else m_run = 0;
         end
         2: begin
            if (legal) begin
               if (p == 0) begin w = 1; m_rot = (m_rot + 1) % 256; end
            end else begin
               m_mode = 3; m_err = 1; m_code = (p < 0) ? 1 : 2;
            end
         end
         default: if (clr) begin m_mode = 0; m_err = 0; m_code = 0; end
      endcase
      if (p >= 0) m_idx = p;
      q.push_back(m_snapshot(w));
      m_prev = m_phq;
      m_phq  = pin;
   endtask

   // ---------------- driver helpers ----------------
   logic [3:0] last;

   task automatic cyc(input logic [3:0] p, input logic c);
      @(negedge clk);
      rstn = 1'b1;
      phase_in = p;
      clr_err = c;
      m_edge(p, c);
      if ($countones(p) == 1) last = p;
   endtask

   task automatic rot(input int n);
      for (int i = 0; i < n; i++) cyc(rl(last), 1'b0);
   endtask

   task automatic rst_cyc();
      @(negedge clk);
      q.push_back(m_snapshot(1'b0));
   endtask

   task automatic async_rst();
      @(negedge clk);
      #2;
      m_reset();
      q.push_back(m_snapshot(1'b0));
      rstn = 1'b0;
      rst_cyc();
      rst_cyc();
      last = 4'b1000;
   endtask

   // ---------------- monitor ----------------
   initial begin
      exp_t a, e;
      forever begin
         @(posedge clk or negedge rstn);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            a = '{idx: idx, locked: locked, wrap: wrap, rot: rot_cnt,
                  err: err, code: err_code};
            checks++;
            if (a !== e) begin
               failures++;
               $display("FAIL outputs t=%0t got idx=%0d locked=%b wrap=%b rot=%0d err=%b code=%b exp idx=%0d locked=%b wrap=%b rot=%0d err=%b code=%b",
                        $time, a.idx, a.locked, a.wrap, a.rot, a.err, a.code,
                        e.idx, e.locked, e.wrap, e.rot, e.err, e.code);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int r;
      logic [3:0] p;
      rstn = 1'b0; phase_in = '0; clr_err = 1'b0;
      m_reset();
      last = 4'b1000;
      rst_cyc();
      rst_cyc();

      // lock, then two rotations
      cyc(4'b0001, 1'b0);
      rot(14);
      // not one-hot while locked, then clean data keeps err sticky
      cyc(4'b0110, 1'b0);
      cyc(4'b0001, 1'b0);
      rot(3);
      // clr_err, relock, then illegal jump 0010 -> 1000
      cyc(rl(last), 1'b1);
      rot(8);
      while (last != 4'b0010) rot(1);
      cyc(4'b1000, 1'b0);
      rot(3);
      cyc(rl(last), 1'b1);
      // ACQ restart via skip, then zero in ACQ
      rot(3);
      cyc(rl(rl(last)), 1'b0);
      rot(5);
      cyc(4'b0000, 1'b0);
      rot(7);
      // clr outside ERROR must do nothing
      cyc(rl(last), 1'b1);
      rot(2);
      // async reset mid-track, then reacquire
      async_rst();
      rot(10);

      // randomized mix of legal steps and faults
      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 99);
         if (r < 80)      p = rl(last);
         else if (r < 86) p = rl(rl(last));
         else if (r < 90) p = 4'b0000;
         else if (r < 95) p = 4'($urandom_range(0, 15));
         else             p = last;
         cyc(p, ($urandom_range(0, 9) == 0));
         if ($urandom_range(0, 999) == 0) async_rst();
      end

      // long clean run: rot_cnt must roll over past 255
      cyc(rl(last), 1'b1);
      rot(1100);
      cyc(rl(last), 1'b0);

      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d required=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ring_phase_monitor.md
Name: ring_phase_monitor

Overview:
Downstream consumer of the ring counter's one-hot output vector. Each clock it checks that the vector is one-hot and that it advanced exactly one position (rotate-left: bit i to bit i+1, MSB to bit 0).
- Acquires lock after a run of legal steps.
- Encodes the active phase to a binary index and pulses on each full rotation.
- Counts rotations.
- Latches a sticky error with a cause code.
Sits between the ring counter and any phase-sequenced logic (scan/mux control) that must not act on a corrupt phase.

Parameters:
WIDTH, 4, ring width; bits of phase_in.
IDXW, 2, index width; must equal clog2(WIDTH).
LOCK_CYC, 4, consecutive legal steps required to lock (1..255).
CNTW, 8, rotation counter width.

Ports:
clk  input  1  system clock, rising edge.
rstn  input  1  asynchronous active-low reset.
phase_in  input  WIDTH  one-hot phase from the ring counter.
clr_err  input  1  synchronous clear of the sticky error (honoured only in ERROR).
idx  output  IDXW  binary index of the current phase.
locked  output  1  high while in TRACK.
wrap  output  1  one-cycle pulse on a legal step from phase WIDTH-1 to phase 0 while in TRACK.
rot_cnt  output  CNTW  rotations counted while in TRACK; wraps modulo 2^CNTW.
err  output  1  sticky error flag.
err_code  output  2  00 none, 01 not one-hot (zero or multi-hot), 10 illegal step.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rstn). Every register clears immediately on rstn=0.
- Reset values: idx=0, locked=0, wrap=0, rot_cnt=0, err=0, err_code=00, state=IDLE, internal ph_q=0, ph_prev=0, acq_cnt=0.
- Pipeline:
  - Stage 1 registers phase_in into ph_q.
  - Stage 2 evaluates ph_q against ph_prev and updates state and all outputs (all registered).
  - Total latency phase_in -> outputs is 2 edges.
- oh = ph_q has exactly one bit set.
- step_ok = oh and ph_q == rotate-left(ph_prev).
- ph_prev <= ph_q every edge.
- idx <= encode(ph_q) whenever oh; otherwise idx holds.
- States:
  - IDLE:
    - oh -> ACQ, acq_cnt=0.
    - Otherwise stay.
    - No error is raised.
  - ACQ:
    - step_ok: acq_cnt+1. When acq_cnt+1 == LOCK_CYC -> TRACK, locked=1.
    - oh but not step_ok: acq_cnt=0, stay in ACQ.
    - Not oh -> IDLE.
    - No error is raised in ACQ.
  - TRACK:
    - step_ok: stay. If ph_prev[WIDTH-1] and ph_q[0]: wrap=1 and rot_cnt+1.
    - Not oh -> ERROR, err_code=01.
    - oh but not step_ok -> ERROR, err_code=10.
    - Entering ERROR sets err=1 and locked=0 on the same edge.
  - ERROR:
    - Stay while clr_err=0. err and err_code hold. rot_cnt holds.
    - clr_err=1 -> IDLE; err=0 and err_code=00 on that edge.
    - clr_err wins over any simultaneous new violation.
- wrap is 0 on every edge except qualifying TRACK steps.
- The step that completes lock does not produce wrap, even if it is a WIDTH-1 -> 0 step.
- rot_cnt is never cleared except by reset; at 2^CNTW-1, the next wrap gives 0.
- clr_err outside ERROR has no effect.
- Reset mid-operation: immediate return to reset values. Reacquisition then needs a fresh LOCK_CYC run.

Test Plan:
- Lock: WIDTH=4, LOCK_CYC=4, rstn released. phase_in=0001 before edge E1, then one rotate-left per edge -> locked=0 through E5; locked=1 after E6; idx follows with 2-edge latency (0001 sampled at E1 gives idx=0 after E2).
- Rotation: continue the run -> wrap=1 for exactly one cycle after E10 (0001 following 1000), rot_cnt=1; then rot_cnt=2 after E14; wrap=0 on all other edges.
- Not one-hot: while locked, force phase_in=0110 for one cycle -> 2 edges later err=1, err_code=01, locked=0, rot_cnt holds; clean 0001 afterwards leaves err=1.
- Illegal step and clear: while locked, jump 0010 -> 1000 -> err_code=10. Pulse clr_err -> err=0, err_code=00 next edge; clean sequence relocks after LOCK_CYC steps.
- ACQ restart: in ACQ after 2 legal steps, inject a skip (0001 -> 0100) -> no err, acq_cnt restarts; locked rises only after 4 further legal steps. phase_in=0000 in ACQ returns to IDLE.
- Async reset: drop rstn mid-TRACK between edges -> all outputs 0 immediately, no clock needed; rot_cnt=0 after release.
